// File: rtl/l2_bus_arbiter.sv
// l2_bus_arbiter: round-robin share of one L2 request port between NUM_REQ
// L1 controllers, one transaction at a time, with a snoop broadcast per grant.
// Ports: clk, rst (async, active-high); req_valid/req_wr/req_addr/req_wdata in,
//   req_ready/resp_valid/resp_rdata out (per requester, addr/wdata packed);
//   l2_req_* out, l2_resp_valid/l2_resp_rdata in; snoop_* out; busy,
//   timeout_err out.
// Option: define L2_ARB_TIMEOUT_EN to bound the WAIT state to TIMEOUT_CYCLES.
module l2_bus_arbiter #(
  parameter int ADDR_WIDTH     = 32,
  parameter int DATA_WIDTH     = 32,
  parameter int NUM_REQ        = 2,
  parameter int IDW            = $clog2(NUM_REQ),
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [NUM_REQ-1:0]           req_valid,
  input  logic [NUM_REQ-1:0]           req_wr,
  input  logic [NUM_REQ*ADDR_WIDTH-1:0] req_addr,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_wdata,
  output logic [NUM_REQ-1:0]           req_ready,
  output logic [NUM_REQ-1:0]           resp_valid,
  output logic [DATA_WIDTH-1:0]        resp_rdata,
  output logic                         l2_req_valid,
  output logic                         l2_req_wr,
  output logic [ADDR_WIDTH-1:0]        l2_req_addr,
  output logic [DATA_WIDTH-1:0]        l2_req_wdata,
  input  logic                         l2_resp_valid,
  input  logic [DATA_WIDTH-1:0]        l2_resp_rdata,
  output logic                         snoop_valid,
  output logic                         snoop_wr,
  output logic [ADDR_WIDTH-1:0]        snoop_addr,
  output logic [IDW-1:0]               snoop_source_id,
  output logic                         busy,
  output logic                         timeout_err
);

  typedef enum logic [1:0] {
    S_IDLE, S_ISSUE, S_WAIT, S_RESP
  } state_t;

  state_t                r_state;
  state_t                w_next;
  logic [IDW-1:0]        r_owner;
  logic [IDW-1:0]        r_ptr;
  logic                  r_wr;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic [DATA_WIDTH-1:0] r_wdata;
  logic [DATA_WIDTH-1:0] r_rdata;
  logic [IDW-1:0]        w_gnt;
  logic                  w_sel_wr;
  logic [ADDR_WIDTH-1:0] w_sel_addr;
  logic [DATA_WIDTH-1:0] w_sel_wdata;
  logic                  w_tmo;

  // r_ptr holds the requester with top priority; scanning from the highest
  // offset down leaves the lowest offset (closest to r_ptr) as the winner.
  function automatic logic [IDW-1:0] rr_pick(
    input logic [NUM_REQ-1:0] v,
    input logic [IDW-1:0]     p
  );
    logic [IDW-1:0] pick;
    logic [IDW-1:0] k;
    pick = p;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      k = IDW'((int'(p) + i) % NUM_REQ);
      if (v[k]) pick = k;
    end
    return pick;
  endfunction

  always_comb begin
    w_gnt       = rr_pick(req_valid, r_ptr);
    w_sel_wr    = 1'b0;
    w_sel_addr  = '0;
    w_sel_wdata = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (w_gnt == IDW'(i)) begin
        w_sel_wr    = req_wr[i];
        w_sel_addr  = req_addr[i*ADDR_WIDTH +: ADDR_WIDTH];
        w_sel_wdata = req_wdata[i*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

`ifdef L2_ARB_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  logic [TW-1:0] r_tcnt;
  logic          r_terr;

  assign w_tmo = (r_state == S_WAIT) && !l2_resp_valid &&
                 (r_tcnt == TW'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_tcnt <= '0;
      r_terr <= 1'b0;
    end else begin
      r_tcnt <= (r_state == S_WAIT) ? r_tcnt + 1'b1 : '0;
      if (w_tmo) r_terr <= 1'b1;
    end
  end

  assign timeout_err = r_terr;
`else
  assign w_tmo       = 1'b0;
  assign timeout_err = 1'b0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      S_IDLE:  if (|req_valid) w_next = S_ISSUE;
      S_ISSUE: w_next = S_WAIT;
      S_WAIT:  if (l2_resp_valid || w_tmo) w_next = S_RESP;
      S_RESP:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_owner <= '0;
      r_ptr   <= '0;
      r_wr    <= 1'b0;
      r_addr  <= '0;
      r_wdata <= '0;
      r_rdata <= '0;
    end else begin
      unique case (r_state)
        S_IDLE: begin
          if (|req_valid) begin
            r_owner <= w_gnt;
            r_wr    <= w_sel_wr;
            r_addr  <= w_sel_addr;
            r_wdata <= w_sel_wdata;
          end
        end
        S_WAIT: begin
          if (l2_resp_valid) r_rdata <= l2_resp_rdata;
          else if (w_tmo)    r_rdata <= '0;
        end
        S_RESP: begin
          r_ptr <= (r_owner == IDW'(NUM_REQ - 1)) ? '0 : r_owner + 1'b1;
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    req_ready       = '0;
    resp_valid      = '0;
    resp_rdata      = '0;
    l2_req_valid    = 1'b0;
    l2_req_wr       = 1'b0;
    l2_req_addr     = '0;
    l2_req_wdata    = '0;
    snoop_valid     = 1'b0;
    snoop_wr        = 1'b0;
    snoop_addr      = '0;
    snoop_source_id = '0;
    busy            = (r_state != S_IDLE);
    unique case (r_state)
      S_ISSUE: begin
        req_ready[r_owner] = 1'b1;
        l2_req_valid       = 1'b1;
        l2_req_wr          = r_wr;
        l2_req_addr        = r_addr;
        l2_req_wdata       = r_wdata;
        snoop_valid        = 1'b1;
        snoop_wr           = r_wr;
        snoop_addr         = r_addr;
        snoop_source_id    = r_owner;
      end
      S_RESP: begin
        resp_valid[r_owner] = 1'b1;
        resp_rdata          = r_wr ? '0 : r_rdata;
      end
      default: ;
    endcase
  end

endmodule

// File: doc/l2_bus_arbiter.md
Name: l2_bus_arbiter

Overview:
- Shares the single L2 request port between NUM_REQ L1 cache controllers, one transaction at a time.
- Round-robin arbitration between requesters.
- Broadcasts every granted transaction on the snoop bus so peer L1s can apply MESI transitions and clear LL/SC reservations.
- Sits between the per-core unified L1 caches and the shared L2.

Parameters:
- ADDR_WIDTH, 32: address width.
- DATA_WIDTH, 32: data width.
- NUM_REQ, 2: number of requesters, at least 2.
- IDW, $clog2(NUM_REQ): requester ID width.
- TIMEOUT_CYCLES, 64: WAIT-state cycle limit (optional feature only).

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous, active-high reset.
- req_valid  in  NUM_REQ  per-requester request; held until req_ready is seen.
- req_wr  in  NUM_REQ  1 = write, 0 = read.
- req_addr  in  NUM_REQ*ADDR_WIDTH  packed addresses; requester i uses slice i.
- req_wdata  in  NUM_REQ*DATA_WIDTH  packed write data.
- req_ready  out  NUM_REQ  one-cycle accept pulse.
- resp_valid  out  NUM_REQ  one-cycle completion pulse to the owning requester.
- resp_rdata  out  DATA_WIDTH  read data; valid while any resp_valid bit is high.
- l2_req_valid  out  1  one-cycle L2 request pulse.
- l2_req_wr, l2_req_addr, l2_req_wdata  out  1/ADDR_WIDTH/DATA_WIDTH  L2 request fields.
- l2_resp_valid  in  1  L2 completion.
- l2_resp_rdata  in  DATA_WIDTH  L2 read data.
- snoop_valid  out  1  snoop broadcast pulse.
- snoop_wr  out  1  snooped transaction is a write.
- snoop_addr  out  ADDR_WIDTH  snooped address.
- snoop_source_id  out  IDW  ID of the granted requester.
- busy  out  1  high whenever the state is not IDLE.
- timeout_err  out  1  sticky error flag.

Behaviour:
- Reset (asynchronous, rst=1):
  - State goes to IDLE and the round-robin pointer is cleared so requester 0 has top priority.
  - All latched fields are zeroed.
  - Every output is 0.
  - Reset mid-transaction abandons it; an L2 response arriving later is ignored because IDLE ignores l2_resp_valid.
- States:
  - IDLE:
    - Arbitrate over req_valid, scanning from (last_owner+1) mod NUM_REQ.
    - Winner's addr, wr, wdata and ID are latched; next state is ISSUE.
    - With no requests, remain in IDLE.
  - ISSUE (exactly 1 cycle):
    - req_ready[owner]=1.
    - l2_req_valid=1 with the latched fields.
    - snoop_valid=1, snoop_wr=latched wr, snoop_addr=latched addr, snoop_source_id=owner.
    - Next state is WAIT.
  - WAIT:
    - On l2_resp_valid, capture l2_resp_rdata and go to RESP.
    - l2_resp_valid during ISSUE is ignored; the L2 contract is response latency of at least 1 cycle.
  - RESP (1 cycle):
    - resp_valid[owner]=1.
    - resp_rdata=captured data for reads, 0 for writes.
    - last_owner=owner; next state is IDLE.
- All outputs are decoded from registered state only; there are no combinational input-to-output paths.
- Latency: req_valid high in cycle 0 → req_ready, l2_req_valid and snoop_valid in cycle 1. An L2 response in cycle k≥2 → resp_valid in cycle k+1.
- Requester contract: drop req_valid the cycle after req_ready. An arbiter that re-sees a still-high valid in IDLE treats it as a new request.
- Simultaneous requests: exactly one grant per transaction; the others wait. Under continuous contention, grants strictly alternate for NUM_REQ=2.
- Only one transaction is ever outstanding; there is no pipelining of L2 requests.
- Address and data slices of non-granted requesters are never forwarded.

Optional Feature:
- Macro: L2_ARB_TIMEOUT_EN.
- Defined:
  - A WAIT-state counter starts at 0 on entry and increments each WAIT cycle.
  - When it reaches TIMEOUT_CYCLES-1 without l2_resp_valid, go to RESP with resp_rdata=0 and set timeout_err=1.
  - timeout_err stays set until reset.
  - A late L2 response arriving in IDLE is dropped.
- Undefined:
  - WAIT waits indefinitely.
  - There is no counter logic, and timeout_err is tied to 0.

Test Plan:
- Single read: req 0 reads 0x1000, L2 returns 0xDEADBEEF 3 cycles after l2_req_valid. Required: req_ready[0] and snoop_valid (snoop_wr=0, addr 0x1000, id 0) in cycle 1; resp_valid[0] with rdata 0xDEADBEEF one cycle after l2_resp_valid.
- Contention: both requesters assert in the same cycle right after reset. Required: requester 0 granted first, requester 1 granted in the next IDLE; with both held continuously for 6 transactions, grant order is 0,1,0,1,0,1.
- Write snoop: req 1 writes 0x5 to 0x1000. Required: l2_req_wr=1, l2_req_wdata=0x5, snoop_wr=1, snoop_source_id=1; resp_rdata=0 on completion.
- Reset mid-WAIT: assert rst while in WAIT, then deliver l2_resp_valid after release. Required: all outputs 0 immediately, busy=0, no resp_valid generated.
- Back-to-back: req 0 re-asserts immediately after resp_valid while req 1 is idle. Required: second grant to 0 with no lost cycles beyond the IDLE arbitration cycle.
- Timeout (with L2_ARB_TIMEOUT_EN, TIMEOUT_CYCLES=8): L2 never responds. Required: resp_valid[owner] with rdata 0 after 8 WAIT cycles, timeout_err=1 and sticky.
